aes_round_ctrl: RTL

- Iterative AES-128 encryption round controller; sits directly upstream of SUBMIX and owns the 128-bit state.
- Applies the initial AddRoundKey and feeds ShiftRows-ordered columns to SUBMIX, two beats per column.
- Collects SUBMIX results, applies AddRoundKey once per round, and sequences rounds 1..NR, including the last_round flag.
- Round keys come from an external combinational key store addressed by round number.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_round_ctrl_shift_rows_col.sv | 25 ++
 rtl/aes_round_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Purpose : shared types and helpers for the iterative AES-128 datapath.
// Latency : n/a (types, constants and a combinational slice helper only).
// Backpr. : n/a.
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BEAT0,
    ST_BEAT1,
    ST_ADDKEY,
    ST_FINISH
  } fsm_t;

  // Column c of a 128-bit state; column 0 occupies bits [127:96].
  function automatic logic [31:0] col_of(input logic [127:0] state, input logic [1:0] c);
    return state[(3 - int'(c)) * 32 +: 32];
  endfunction

endpackage

// File: rtl/aes_round_ctrl_shift_rows_col.sv
// Purpose : one ShiftRows output column; byte r is taken from state column (col+r) mod 4, row r.
// Latency : combinational.
// Backpr. : none.
// Ports   : state (128-bit AES state), col (output column index), column (32-bit shifted column).
module shift_rows_col
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [1:0]   col,
  output logic [31:0]  column
);

  logic [31:0] src;

  always_comb begin
    column = '0;
    src    = '0;
    for (int r = 0; r < 4; r++) begin
      // Two-bit add wraps naturally, giving the mod-4 column rotation.
      src = col_of(state, col + 2'(r));
      column[31 - 8 * r -: 8] = src[31 - 8 * r -: 8];
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Purpose : iterative AES-128 round sequencer; owns the state, feeds SUBMIX one column per 3 cycles.
// Latency : done pulses 13*NR+1 cycles after the start edge (131 for AES-128).
// Backpr. : none; start is ignored unless idle, no request queuing.
// Ports   : clk/rst; start + block_in request; busy, done, block_out result;
//           rk_round/rk_in combinational key-store lookup;
//           sm_state/sm_index/sm_last to SUBMIX, sm_result back from it (same cycle).
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] block_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] block_out,
  output logic [3:0]   rk_round,
  input  logic [127:0] rk_in,
  output logic [31:0]  sm_state,
  output logic         sm_index,
  output logic         sm_last,
  input  logic [31:0]  sm_result
);

  localparam logic [3:0] NR4 = 4'(NR);

  fsm_t         fsm;
  logic [127:0] state;   // round input, read only by ShiftRows
  logic [127:0] nstate;  // SUBMIX results collected for the current round
  logic [3:0]   round;
  logic [1:0]   col;
  logic [31:0]  sr_col;

  shift_rows_col u_shift_rows_col (
    .state  (state),
    .col    (col),
    .column (sr_col)
  );

  // Key 0 is needed at the start edge; afterwards the store follows the round counter.
  assign rk_round = (fsm == ST_IDLE) ? 4'd0 : round;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= ST_IDLE;
      state     <= '0;
      nstate    <= '0;
      round     <= '0;
      col       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      block_out <= '0;
      sm_state  <= '0;
      sm_index  <= 1'b0;
      sm_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            state <= block_in ^ rk_in;
            round <= 4'd1;
            col   <= 2'd0;
            busy  <= 1'b1;
            fsm   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          sm_state <= sr_col;
          sm_index <= 1'b0;
          sm_last  <= (round == NR4);
          fsm      <= ST_BEAT0;
        end
        ST_BEAT0: begin
          // Second pass of the same column through SUBMIX.
          sm_state <= sm_result;
          sm_index <= 1'b1;
          fsm      <= ST_BEAT1;
        end
        ST_BEAT1: begin
          nstate[(3 - int'(col)) * 32 +: 32] <= sm_result;
          if (col == 2'd3) begin
            fsm <= ST_ADDKEY;
          end else begin
            col <= col + 2'd1;
            fsm <= ST_LOAD;
          end
        end
        ST_ADDKEY: begin
          state <= nstate ^ rk_in;
          col   <= 2'd0;
          if (round == NR4) begin
            fsm <= ST_FINISH;
          end else begin
            round <= round + 4'd1;
            fsm   <= ST_LOAD;
          end
        end
        ST_FINISH: begin
          block_out <= state;
          done      <= 1'b1;
          busy      <= 1'b0;
          fsm       <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule
